// File: rtl/feature_pkg.sv
// Shared constants, state encoding and helpers for the feature frame packer.
package feature_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_FEAT = 42;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    function automatic int word_offset(input int i, input int width);
        return i * width;
    endfunction

endpackage

// File: rtl/feature_frame_reg.sv
// NUM_FEAT x WIDTH register bank: single-word indexed write or whole-frame load,
// read back as one packed flat vector.
module feature_frame_reg
    import feature_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_FEAT = DEF_NUM_FEAT,
    parameter int IDX_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [IDX_W-1:0]          wr_idx,
    input  logic [WIDTH-1:0]          wr_word,
    input  logic                      load,
    input  logic [NUM_FEAT*WIDTH-1:0] load_data,
    output logic [NUM_FEAT*WIDTH-1:0] flat
);

    logic [WIDTH-1:0] mem [NUM_FEAT];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FEAT; i++) begin
            if (rst) begin
                mem[i] <= '0;
            end else if (load) begin
                mem[i] <= load_data[word_offset(i, WIDTH) +: WIDTH];
            end else if (wr_en && wr_idx == IDX_W'(i)) begin
                mem[i] <= wr_word;
            end
        end
    end

    for (genvar g = 0; g < NUM_FEAT; g++) begin : g_flat
        assign flat[g*WIDTH +: WIDTH] = mem[g];
    end

endmodule

// File: rtl/feature_frame_packer.sv
// Double-buffered packer: assembles NUM_FEAT feature words into one flat frame,
// with frame-boundary error pulses and a delivered-frame counter.
module feature_frame_packer
    import feature_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_FEAT = DEF_NUM_FEAT,
    parameter int CNT_W    = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [NUM_FEAT*WIDTH-1:0] frame_data,
    output logic                      frame_valid,
    input  logic                      frame_ready,
    output logic [CNT_W-1:0]          frame_count,
    output logic                      err_short,
    output logic                      err_long
);

    localparam int IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);

    state_t                    state;
    logic [IDX_W-1:0]          idx;
    logic                      discard;
    logic                      accept;
    logic                      handoff;
    logic                      load_out;
    logic                      fill_we;
    logic [NUM_FEAT*WIDTH-1:0] fill_flat;

    assign in_ready = (state != FULL);
    assign accept   = in_valid && in_ready;
    assign handoff  = frame_valid && frame_ready;
    assign fill_we  = accept && (state == FILL);
    // Output register is free when empty or being emptied this very cycle.
    assign load_out = (state == FULL) && (!frame_valid || frame_ready);

    feature_frame_reg #(
        .WIDTH    (WIDTH),
        .NUM_FEAT (NUM_FEAT),
        .IDX_W    (IDX_W)
    ) u_fill (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (fill_we),
        .wr_idx    (idx),
        .wr_word   (in_data),
        .load      (1'b0),
        .load_data ('0),
        .flat      (fill_flat)
    );

    feature_frame_reg #(
        .WIDTH    (WIDTH),
        .NUM_FEAT (NUM_FEAT),
        .IDX_W    (IDX_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (1'b0),
        .wr_idx    ('0),
        .wr_word   ('0),
        .load      (load_out),
        .load_data (fill_flat),
        .flat      (frame_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FILL;
            idx         <= '0;
            discard     <= 1'b0;
            frame_valid <= 1'b0;
            frame_count <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            if (handoff) begin
                frame_count <= frame_count + 1'b1;
            end
            if (load_out) begin
                frame_valid <= 1'b1;
            end else if (handoff) begin
                frame_valid <= 1'b0;
            end
            unique case (state)
                FILL: begin
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            idx      <= '0;
                            state    <= FULL;
                            discard  <= !in_last;
                            err_long <= !in_last;
                        end else if (in_last) begin
                            idx       <= '0;
                            err_short <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (load_out) begin
                        state <= discard ? DISCARD : FILL;
                    end
                end
                DISCARD: begin
                    if (accept && in_last) begin
                        state   <= FILL;
                        discard <= 1'b0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_feature_frame_packer.sv
// Scoreboarded random and directed bench for feature_frame_packer.
module tb_feature_frame_packer;

    localparam int W  = 32;
    localparam int N  = 42;
    localparam int CW = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   in_data;
    logic           in_valid;
    logic           in_last;
    logic           in_ready;
    logic [N*W-1:0] frame_data;
    logic           frame_valid;
    logic           frame_ready;
    logic [CW-1:0]  frame_count;
    logic           err_short;
    logic           err_long;

    always #5 clk = ~clk;

    feature_frame_packer #(.WIDTH(W), .NUM_FEAT(N), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_count (frame_count),
        .err_short   (err_short),
        .err_long    (err_long)
    );

    int             nvec = 0;
    int             nfail = 0;
    logic [N*W-1:0] frame_q [$];
    int             err_q [$];
    int             ready_mode = 1;
    logic [CW-1:0]  exp_cnt = '0;
    logic           prev_valid = 1'b0;
    logic           prev_ready = 1'b0;
    logic [N*W-1:0] prev_data;
    int             bubbles = 0;
    logic           bub_win = 1'b0;

    // Random consumer backpressure unless a directed test owns frame_ready.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) frame_ready = ($urandom_range(0, 2) != 0);
    end

    always @(negedge clk) begin : monitor
        logic [N*W-1:0] exp;
        int code;
        int got;
        if (rst) begin
            exp_cnt    = '0;
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready) begin
                nvec++;
                if (!frame_valid || frame_data !== prev_data) begin
                    nfail++;
                    $display("FAIL hold: frame_valid=%0b data_stable=%0b, required 1/1",
                             frame_valid, frame_data === prev_data);
                end
            end
            if (bub_win && !in_ready) bubbles++;
            if (frame_valid && frame_ready) begin
                nvec++;
                if (frame_q.size() == 0) begin
                    nfail++;
                    $display("FAIL frame: unexpected delivery, none required");
                end else begin
                    exp = frame_q.pop_front();
                    if (frame_data !== exp) begin
                        nfail++;
                        for (int k = 0; k < N; k++) begin
                            if (frame_data[k*W +: W] !== exp[k*W +: W]) begin
                                $display("FAIL frame: word %0d got %h required %h",
                                         k, frame_data[k*W +: W], exp[k*W +: W]);
                                break;
                            end
                        end
                    end
                end
                nvec++;
                if (frame_count !== exp_cnt) begin
                    nfail++;
                    $display("FAIL count_at_handoff: got %0d required %0d",
                             frame_count, exp_cnt);
                end
                exp_cnt = exp_cnt + 1'b1;
            end
            if (err_short || err_long) begin
                got = (err_short && err_long) ? 3 : (err_short ? 1 : 2);
                nvec++;
                if (err_q.size() == 0) begin
                    nfail++;
                    $display("FAIL err: pulse code %0d, none required", got);
                end else begin
                    code = err_q.pop_front();
                    if (got != code) begin
                        nfail++;
                        $display("FAIL err: got code %0d required %0d", got, code);
                    end
                end
            end
            prev_valid = frame_valid;
            prev_ready = frame_ready;
            prev_data  = frame_data;
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic send_word(input logic [W-1:0] d, input logic last, input int gap);
        int n;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 500);
        if (!in_ready) begin
            nfail++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles", n);
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
            $fatal(1, "stalled");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Source frame of len words; mode 0 random, 1 index value, 2 constant k.
    task automatic send_frame(input int len, input int mode, input logic [W-1:0] k,
                              input int maxgap);
        logic [N*W-1:0] flat = '0;
        logic [W-1:0]   d;
        for (int i = 0; i < len; i++) begin
            d = (mode == 0) ? W'($urandom) : ((mode == 1) ? W'(i) : k);
            send_word(d, i == len - 1, (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
            if (i < N) flat[i*W +: W] = d;
            if (i == N - 1) begin
                frame_q.push_back(flat);
                if (len > N) err_q.push_back(2);
            end
            if (i == len - 1 && len < N) err_q.push_back(1);
        end
    endtask

    task automatic drain();
        int n = 0;
        ready_mode = 0;
        while (frame_q.size() != 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        nvec++;
        if (frame_q.size() != 0 || err_q.size() != 0) begin
            nfail++;
            $display("FAIL drain: %0d frames %0d errors outstanding, required 0",
                     frame_q.size(), err_q.size());
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_data     = '0;
        frame_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_valid", frame_valid, 0);
        chk("rst_count", frame_count, 0);
        chk("rst_data_zero", frame_data === '0, 1);
        chk("rst_errs", {err_short, err_long}, 0);
        @(posedge clk);
        #1;

        // Nominal: word i holds value i.
        frame_ready = 1'b1;
        send_frame(N, 1, '0, 0);
        drain();
        chk("nominal_count", frame_count, 1);

        // Back-to-back: one in_ready bubble per frame.
        ready_mode  = 1;
        frame_ready = 1'b1;
        bubbles     = 0;
        bub_win     = 1'b1;
        repeat (3) send_frame(N, 0, '0, 0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        bub_win = 1'b0;
        chk("b2b_bubbles", bubbles, 3);
        drain();
        chk("b2b_count", frame_count, 4);

        // Backpressure: A held, B fills, packer stalls.
        ready_mode  = 1;
        frame_ready = 1'b0;
        send_frame(N, 2, 32'hAAAAAAAA, 0);
        send_frame(N, 2, 32'h55555555, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_stall_in_ready", in_ready, 0);
        end
        chk("bp_valid", frame_valid, 1);
        chk("bp_hold_A", frame_data === {N{32'hAAAAAAAA}}, 1);
        @(posedge clk);
        #1 frame_ready = 1'b1;
        @(posedge clk);
        #1 frame_ready = 1'b0;
        @(negedge clk);
        chk("bp_B_data", frame_data === {N{32'h55555555}}, 1);
        chk("bp_B_valid", frame_valid, 1);
        chk("bp_in_ready_back", in_ready, 1);
        @(posedge clk);
        #1;
        drain();
        chk("bp_count", frame_count, 6);

        // Short then good frame.
        send_frame(10, 0, '0, 1);
        send_frame(N, 0, '0, 1);
        drain();
        chk("short_count", frame_count, 7);

        // Long then good frame.
        send_frame(45, 0, '0, 1);
        send_frame(N, 0, '0, 0);
        drain();
        chk("long_count", frame_count, 9);

        // Reset in the middle of a frame.
        ready_mode  = 1;
        frame_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_word(W'($urandom), 1'b0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_valid", frame_valid, 0);
        chk("mid_rst_count", frame_count, 0);
        @(posedge clk);
        #1;
        send_frame(N, 0, '0, 0);
        drain();
        chk("post_rst_count", frame_count, 1);

        // Random mix of short, exact and long source frames.
        for (int r = 0; r < 14; r++) begin
            int t;
            int len;
            t = $urandom_range(0, 5);
            len = (t == 0) ? $urandom_range(1, N - 1)
                : ((t == 1) ? $urandom_range(N + 1, N + 5) : N);
            send_frame(len, 0, '0, 2);
        end
        drain();
        chk("final_count", frame_count, exp_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
